uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmitter. Accepts a parallel byte on a valid strobe, then drives the serial line one bit per CLK: start, data LSB first, optional parity, stop.
- Owns the Busy flag shared with parity_calc. Samples parity_calc's registered parity output during the parity slot.
- Sits between the TX register interface and the TX_OUT pad. Works at bit rate: one CLK equals one bit time.

Parameters:
- WIDTH, 8, data bits per frame (1..16)
- IDLE_LEVEL, 1'b1, line level driven when idle and during stop

Ports:
- CLK  in  1  bit-rate clock
- RST  in  1  asynchronous active-low reset
- DATA  in  WIDTH  parallel data, valid with Data_Valid
- Data_Valid  in  1  one-cycle request to send DATA
- parity_enable  in  1  insert parity bit after data
- parity  in  1  parity bit from parity_calc (registered there)
- TX_OUT  out  1  serial line
- Busy  out  1  frame in progress; fed back to parity_calc
- ser_done  out  1  one-cycle pulse in the last stop-bit cycle
- bit_idx  out  $clog2(WIDTH)  index of the data bit currently on TX_OUT (debug/monitor)

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous, active-low.
- Reset values: state=IDLE, TX_OUT=IDLE_LEVEL, Busy=0, ser_done=0, bit_idx=0, shift register=0, latched parity enable=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - TX_OUT=IDLE_LEVEL, Busy=0.
  - On Data_Valid=1, capture DATA into the shift register, latch parity_enable, go to START.
  - Data_Valid while not in IDLE is ignored; it is neither queued nor errored.
- START:
  - 1 cycle, TX_OUT=~IDLE_LEVEL, Busy=1.
  - Go to DATA with bit_idx=0.
- DATA:
  - WIDTH cycles. TX_OUT = shift register [0], shifting right each cycle. bit_idx increments 0..WIDTH-1.
  - When bit_idx==WIDTH-1, go to PAR if latched enable=1, else STOP.
  - bit_idx does not wrap inside a frame. It returns to 0 on entry to START.
- PAR:
  - 1 cycle, TX_OUT = parity input sampled in this cycle.
  - parity_calc has loaded data on the accept edge and registered parity one cycle later, so parity is stable from the START cycle onward.
- STOP:
  - 1 cycle, TX_OUT=IDLE_LEVEL, ser_done=1.
  - Go to IDLE; Busy drops on the next edge.
- Timing:
  - Latency: TX_OUT shows the start bit in the first cycle after the accepting edge.
  - Busy is high for exactly 2+WIDTH+P cycles, where P is the latched parity enable.
  - Minimum frame spacing is one IDLE cycle; back-to-back accept in STOP is not allowed.
- parity_enable changes mid-frame have no effect on the frame in progress; the latched copy is used.
- Reset mid-frame: immediate return to reset values; line goes to IDLE_LEVEL with no partial stop bit.
- DATA changes after acceptance do not affect the frame in progress.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined:
  - Adds an input two_stop (1 bit), latched at acceptance alongside parity_enable.
  - When latched two_stop=1, STOP lasts 2 cycles. ser_done pulses only in the second cycle, and Busy length grows by 1.
- Undefined: the port is absent and there is always exactly one stop bit.

Test Plan:
- Reset check: hold RST=0 for 3 cycles, then release -> TX_OUT=1, Busy=0, ser_done=0, bit_idx=0; no transitions for 10 idle cycles.
- Even-parity frame: DATA=0xA5, parity_enable=1, parity_calc type=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; Busy high for 11 cycles; ser_done in cycle 11.
- Odd-parity frame: DATA=0x01, parity_enable=1, type=1 -> TX_OUT 0,1,0,0,0,0,0,0,0,0,1; parity slot=0.
- No parity: DATA=0xFF, parity_enable=0 -> TX_OUT 0, eight 1s, 1; Busy high for 10 cycles. Toggling parity_enable to 1 mid-frame changes nothing.
- Ignored request and back-to-back: pulse Data_Valid with DATA=0x3C during the DATA state -> ignored, frame still 0xA5. Next Data_Valid one cycle after Busy falls -> new start bit on the following cycle.
- Reset mid-frame: assert RST during data bit 4 -> TX_OUT=1 and Busy=0 immediately. After release, DATA=0x55 transmits cleanly. With UART_TX_TWO_STOP_EN and two_stop=1, repeat 0x55 -> two stop cycles, Busy high for 12 cycles.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl -- UART transmit frame sequencer (one CLK = one bit time)
//
// Accepts a parallel word on a one-cycle Data_Valid strobe while idle, then
// drives TX_OUT with: start bit, WIDTH data bits LSB first, an optional
// parity bit taken from parity_calc, and the stop bit(s). Every output is
// registered; nothing combinational reaches the ports.
//
// Optional feature: define UART_TX_TWO_STOP_EN to add the two_stop input,
// which (latched at acceptance) stretches the stop phase to two cycles.
//
// Parameters:
//   WIDTH       data bits per frame (1..16)
//   IDLE_LEVEL  line level when idle and during stop
//
// Ports:
//   CLK            bit-rate clock
//   RST            asynchronous active-low reset
//   DATA           parallel data, sampled with Data_Valid
//   Data_Valid     one-cycle send request (ignored unless idle)
//   parity_enable  insert a parity bit after the data (latched at accept)
//   parity         registered parity bit from parity_calc
//   two_stop       two stop bits (only with UART_TX_TWO_STOP_EN)
//   TX_OUT         serial line
//   Busy           frame in progress, fed back to parity_calc
//   ser_done       one-cycle pulse in the final stop-bit cycle
//   bit_idx        index of the data bit currently on TX_OUT
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1,
  localparam int  IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             Data_Valid,
  input  logic             parity_enable,
  input  logic             parity,
`ifdef UART_TX_TWO_STOP_EN
  input  logic             two_stop,
`endif
  output logic             TX_OUT,
  output logic             Busy,
  output logic             ser_done,
  output logic [IDX_W-1:0] bit_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             par_en_q;
  logic             last_stop;   // this stop cycle is the final one

`ifdef UART_TX_TWO_STOP_EN
  logic             two_stop_q;  // cleared after the first of two stop cycles
  assign last_stop = ~two_stop_q;
`else
  assign last_stop = 1'b1;
`endif

  // Outputs are computed one edge ahead: each branch loads the value that
  // TX_OUT/Busy/ser_done must show in the state being entered.
  // NOTE: all state and outputs use non-blocking assignments so every
  // branch sees the pre-edge values, regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      TX_OUT     <= IDLE_LEVEL;
      Busy       <= 1'b0;
      ser_done   <= 1'b0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      two_stop_q <= 1'b0;
`endif
    end else begin
      ser_done <= 1'b0;  // pulse, re-armed only when entering the last stop
      case (state)
        S_IDLE: begin
          TX_OUT <= IDLE_LEVEL;
          Busy   <= 1'b0;
          if (Data_Valid) begin
            shreg      <= DATA;
            par_en_q   <= parity_enable;
`ifdef UART_TX_TWO_STOP_EN
            two_stop_q <= two_stop;
`endif
            bit_idx    <= '0;
            TX_OUT     <= ~IDLE_LEVEL;
            Busy       <= 1'b1;
            state      <= S_START;
          end
        end

        S_START: begin
          // bit_idx already 0 from acceptance; present data bit 0
          TX_OUT <= shreg[0];
          shreg  <= shreg >> 1;
          state  <= S_DATA;
        end

        S_DATA: begin
          if (bit_idx == LAST_IDX) begin
            // bit_idx holds at WIDTH-1 until the next frame starts
            if (par_en_q) begin
              TX_OUT <= parity;
              state  <= S_PAR;
            end else begin
              TX_OUT   <= IDLE_LEVEL;
              ser_done <= last_stop;
              state    <= S_STOP;
            end
          end else begin
            TX_OUT  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end

        S_PAR: begin
          TX_OUT   <= IDLE_LEVEL;
          ser_done <= last_stop;
          state    <= S_STOP;
        end

        S_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
          if (two_stop_q) begin
            // first of two stop cycles: stay, next cycle is the final one
            two_stop_q <= 1'b0;
            ser_done   <= 1'b1;
          end else
`endif
          begin
            TX_OUT <= IDLE_LEVEL;
            Busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end

        default: begin
          TX_OUT <= IDLE_LEVEL;
          Busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
